// File: rtl/vrf_access_scheduler_pkg.sv
// Shared definitions for the VRF access scheduler: FSM state encoding,
// requester command layout and the field widths derived from the vector length.
package vrf_sched_pkg;

  localparam int unsigned DEF_VECTOR_LENGTH = 32'd1024;

  // Width of the vector_length field: one extra bit so a full register fits.
  function automatic int unsigned vlw_f(input int unsigned vector_length);
    return $clog2(vector_length / 32'd32) + 32'd1;
  endfunction

  localparam int unsigned VLW    = vlw_f(DEF_VECTOR_LENGTH);
  localparam int unsigned TYPE_W = 32'd2;
  localparam int unsigned REG_W  = 32'd5;
  localparam int unsigned VMUL_W = 32'd2;
  localparam int unsigned ALU_W  = 32'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_ACK   = 2'd2,
    ST_RUN   = 2'd3
  } vrf_sched_state_t;

  typedef struct packed {
    logic [TYPE_W-1:0] acc_type;
    logic [REG_W-1:0]  vs1;
    logic [REG_W-1:0]  vs2;
    logic [REG_W-1:0]  vd;
    logic [VMUL_W-1:0] vmul;
    logic [VLW-1:0]    vl;
    logic [ALU_W-1:0]  alu_exe_time;
  } vrf_cmd_t;

  localparam int unsigned CMD_W = $bits(vrf_cmd_t);

endpackage

// File: rtl/vrf_access_scheduler_if.sv
// Request bus between the two requesters (arithmetic issue, load/store) and
// the scheduler: per-requester valid, one-hot ready and the two command words.
interface vrf_access_scheduler_if;
  import vrf_sched_pkg::*;

  logic [1:0] req_valid;
  logic [1:0] req_ready;
  vrf_cmd_t   req0_cmd;
  vrf_cmd_t   req1_cmd;

  modport master (output req_valid, req0_cmd, req1_cmd, input req_ready);
  modport slave  (input req_valid, req0_cmd, req1_cmd, output req_ready);
endinterface

// File: rtl/vrf_access_scheduler_rr_arbiter.sv
// Two-way round-robin grant; the pointer moves to the losing requester on
// every accepted grant.
module vrf_rr_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] valid,
  output logic [1:0] grant,
  output logic       accept
);

  logic rr_r;

  // Prefer the pointed-to requester, fall back to the other one.
  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (rr_r == 1'b0) begin
        if (valid[0])      grant = 2'b01;
        else if (valid[1]) grant = 2'b10;
        else               grant = 2'b00;
      end else begin
        if (valid[1])      grant = 2'b10;
        else if (valid[0]) grant = 2'b01;
        else               grant = 2'b00;
      end
    end else begin
      grant = 2'b00;
    end
  end

  assign accept = |grant;

  // Pointer update: the requester just served loses priority.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_r <= 1'b0;
    end else if (accept) begin
      rr_r <= grant[0];
    end
  end

endmodule

// File: rtl/vrf_access_scheduler.sv
// Arbitrates two requesters onto the VRF address generator and sequences it.
// Optional watchdog with sticky error_o is enabled by VRF_SCHED_TIMEOUT_EN.
module vrf_access_scheduler
  import vrf_sched_pkg::*;
#(
  parameter int unsigned VECTOR_LENGTH = DEF_VECTOR_LENGTH
`ifdef VRF_SCHED_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 32'd4096
`endif
) (
  input  logic                                 clk,
  input  logic                                 reset,
  vrf_access_scheduler_if.slave                req_bus,
  output logic [1:0]                           vrf_type_of_access_o,
  output logic [4:0]                           vs1_address_o,
  output logic [4:0]                           vs2_address_o,
  output logic [4:0]                           vd_address_o,
  output logic [1:0]                           vmul_o,
  output logic [vlw_f(VECTOR_LENGTH)-1:0]      vector_length_o,
  output logic [2:0]                           alu_exe_time_o,
  output logic                                 gen_start_o,
  input  logic                                 gen_ready_i,
  output logic                                 busy_o,
  output logic                                 grant_id_o,
  output logic                                 done_o
`ifdef VRF_SCHED_TIMEOUT_EN
  , output logic                               error_o
`endif
);

  vrf_sched_state_t state_r;
  vrf_cmd_t         cmd_r;
  vrf_cmd_t         sel_cmd_s;
  logic             grant_id_r;
  logic             gen_start_r;
  logic             skip_r;
  logic [1:0]       grant_s;
  logic             accept_s;
  logic             arb_en_s;
  logic             timeout_s;
  logic             run_done_s;

  // Gating with reset keeps req_ready low while reset is asserted.
  assign arb_en_s = reset && (state_r == ST_IDLE) && gen_ready_i;

  vrf_rr_arbiter u_arb (
    .clk    (clk),
    .reset  (reset),
    .enable (arb_en_s),
    .valid  (req_bus.req_valid),
    .grant  (grant_s),
    .accept (accept_s)
  );

  assign req_bus.req_ready = grant_s;

  // Command of the requester being granted this cycle.
  always_comb begin
    sel_cmd_s = req_bus.req0_cmd;
    if (grant_s[1]) sel_cmd_s = req_bus.req1_cmd;
    else            sel_cmd_s = req_bus.req0_cmd;
  end

`ifdef VRF_SCHED_TIMEOUT_EN
  localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 32'd1);
  logic [TCW-1:0] tcnt_r;
  logic           error_r;

  assign timeout_s = (state_r == ST_RUN) && !skip_r && (tcnt_r == TCW'(TIMEOUT_CYCLES - 32'd1));

  // Watchdog: held at zero outside RUN, counts RUN cycles, error is sticky.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcnt_r  <= {TCW{1'b0}};
      error_r <= 1'b0;
    end else if (state_r != ST_RUN) begin
      tcnt_r <= {TCW{1'b0}};
    end else begin
      tcnt_r <= tcnt_r + TCW'(1);
      if (timeout_s) error_r <= 1'b1;
    end
  end

  assign error_o = error_r;
`else
  assign timeout_s = 1'b0;
`endif

  // A zero-length command passes through RUN for a single done cycle.
  assign run_done_s = (state_r == ST_RUN) && (gen_ready_i || skip_r) && !timeout_s;

  // Sequencer and configuration registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      cmd_r       <= vrf_cmd_t'({CMD_W{1'b0}});
      grant_id_r  <= 1'b0;
      gen_start_r <= 1'b0;
      skip_r      <= 1'b0;
    end else begin
      gen_start_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            cmd_r      <= sel_cmd_s;
            grant_id_r <= grant_s[1];
            if (sel_cmd_s.vl == {VLW{1'b0}}) begin
              skip_r  <= 1'b1;
              state_r <= ST_RUN;
            end else begin
              skip_r      <= 1'b0;
              gen_start_r <= 1'b1;
              state_r     <= ST_START;
            end
          end
        end
        ST_START: state_r <= ST_ACK;
        // The generator only drops ready one cycle after start, so ACK ignores it.
        ST_ACK:   state_r <= ST_RUN;
        ST_RUN: begin
          if (timeout_s || run_done_s) state_r <= ST_IDLE;
        end
        default:  state_r <= ST_IDLE;
      endcase
    end
  end

  assign vrf_type_of_access_o = cmd_r.acc_type;
  assign vs1_address_o        = cmd_r.vs1;
  assign vs2_address_o        = cmd_r.vs2;
  assign vd_address_o         = cmd_r.vd;
  assign vmul_o               = cmd_r.vmul;
  assign vector_length_o      = cmd_r.vl;
  assign alu_exe_time_o       = cmd_r.alu_exe_time;
  assign gen_start_o          = gen_start_r;
  assign grant_id_o           = grant_id_r;
  assign busy_o               = (state_r != ST_IDLE);
  assign done_o               = run_done_s;

endmodule

// File: tb/tb_vrf_access_scheduler.sv
// Table-driven bench for vrf_access_scheduler with a scoreboard of granted
// commands, plus hand sequences for stall, reset-in-RUN and watchdog cases.
module tb_vrf_access_scheduler;
  import vrf_sched_pkg::*;

  typedef struct {
    logic [1:0] valid;
    vrf_cmd_t   c0;
    vrf_cmd_t   c1;
    int         lat;
    logic       exp_id;
  } vec_t;

  typedef struct {
    logic     id;
    vrf_cmd_t cmd;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic gen_ready;
  logic [1:0] type_o;
  logic [4:0] vs1_o, vs2_o, vd_o;
  logic [1:0] vmul_o;
  logic [VLW-1:0] vl_o;
  logic [2:0] alu_o;
  logic gen_start, busy, grant_id, done;
`ifdef VRF_SCHED_TIMEOUT_EN
  logic error_o;
`endif

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_exp = 0;
  int prev_acc = 0;
  int prev_int_exp = 0;
  exp_t sb[$];
  vec_t tbl[11];

  vrf_access_scheduler_if bus();

  vrf_access_scheduler #(
    .VECTOR_LENGTH (1024)
`ifdef VRF_SCHED_TIMEOUT_EN
    , .TIMEOUT_CYCLES (16)
`endif
  ) dut (
    .clk                  (clk),
    .reset                (rst_n),
    .req_bus              (bus),
    .vrf_type_of_access_o (type_o),
    .vs1_address_o        (vs1_o),
    .vs2_address_o        (vs2_o),
    .vd_address_o         (vd_o),
    .vmul_o               (vmul_o),
    .vector_length_o      (vl_o),
    .alu_exe_time_o       (alu_o),
    .gen_start_o          (gen_start),
    .gen_ready_i          (gen_ready),
    .busy_o               (busy),
    .grant_id_o           (grant_id),
    .done_o               (done)
`ifdef VRF_SCHED_TIMEOUT_EN
    , .error_o            (error_o)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [CMD_W-1:0] cfg_now();
    return {type_o, vs1_o, vs2_o, vd_o, vmul_o, vl_o, alu_o};
  endfunction

  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      check("done_excl_ready", {30'd0, bus.req_ready}, 32'd0);
    end
  end

  function automatic vec_t mk(input logic [1:0] valid, input logic id, input int lat, input bit zero);
    vec_t v;
    v.valid  = valid;
    v.exp_id = id;
    v.lat    = lat;
    v.c0     = vrf_cmd_t'(CMD_W'($urandom));
    v.c1     = vrf_cmd_t'(CMD_W'($urandom));
    v.c0.vl  = VLW'($urandom_range(63, 1));
    v.c1.vl  = VLW'($urandom_range(63, 1));
    if (zero) begin
      if (id) v.c1.vl = '0;
      else    v.c0.vl = '0;
    end
    return v;
  endfunction

  // Runs one operation from the cycle after accept up to its done pulse.
  task automatic complete_txn(input vrf_cmd_t cmd, input int lat, input string tag);
    logic [CMD_W-1:0] snap;
    int k;
    bit seen;
    exp_t e;
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    @(negedge clk);
    k = 1;
    if (cmd.vl == '0) begin
      check({tag, "_start_vl0"}, {31'd0, gen_start}, 32'd0);
      check({tag, "_done_vl0"}, {31'd0, done}, 32'd1);
    end else begin
      check({tag, "_start"}, {31'd0, gen_start}, 32'd1);
      snap = cfg_now();
      seen = 1'b0;
      while (!seen && k < lat + 10) begin
        @(posedge clk); #1;
        k++;
        gen_ready = (k >= 3 + lat);
        @(negedge clk);
        check({tag, "_start_pulse"}, {31'd0, gen_start}, 32'd0);
        if (busy === 1'b1) check({tag, "_stable"}, cfg_now(), snap);
        if (done === 1'b1) seen = 1'b1;
      end
      check({tag, "_done_cyc"}, k, 3 + lat);
    end
    done_exp++;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_cfg"}, cfg_now(), e.cmd);
      check({tag, "_grant_id"}, {31'd0, grant_id}, {31'd0, e.id});
    end
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    exp_t e;
    @(posedge clk); #1;
    bus.req_valid = v.valid;
    bus.req0_cmd  = v.c0;
    bus.req1_cmd  = v.c1;
    gen_ready     = 1'b1;
    @(negedge clk);
    check({tag, "_ready"}, {30'd0, bus.req_ready}, v.exp_id ? 32'd2 : 32'd1);
    if (prev_int_exp != 0) check({tag, "_interval"}, cyc - prev_acc, prev_int_exp);
    prev_acc = cyc;
    e.id  = v.exp_id;
    e.cmd = v.exp_id ? v.c1 : v.c0;
    sb.push_back(e);
    complete_txn(e.cmd, v.lat, tag);
    prev_int_exp = (e.cmd.vl == '0) ? 2 : ((v.lat == 0) ? 4 : 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", vectors);
    $fatal(1);
  end

  initial begin
    vrf_cmd_t cx;
    exp_t e;
    int k;

    tbl[0]  = mk(2'b11, 1'b0, 5, 1'b0);
    tbl[0].c0.acc_type = 2'b11;
    tbl[0].c0.vl       = VLW'(32);
    tbl[1]  = mk(2'b11, 1'b1, 0, 1'b0);
    tbl[2]  = mk(2'b11, 1'b0, 0, 1'b0);
    tbl[3]  = mk(2'b11, 1'b1, 0, 1'b0);
    tbl[4]  = mk(2'b10, 1'b1, 0, 1'b1);
    tbl[5]  = mk(2'b11, 1'b0, 0, 1'b0);
    tbl[6]  = mk(2'b01, 1'b0, 1, 1'b0);
    tbl[7]  = mk(2'b11, 1'b1, 0, 1'b0);
    tbl[8]  = mk(2'b10, 1'b1, 2, 1'b0);
    tbl[9]  = mk(2'b11, 1'b0, 0, 1'b1);
    tbl[10] = mk(2'b11, 1'b1, 0, 1'b0);

    // Reset with requests pending: everything must stay at zero.
    rst_n         = 1'b0;
    gen_ready     = 1'b1;
    bus.req_valid = 2'b11;
    bus.req0_cmd  = tbl[0].c0;
    bus.req1_cmd  = tbl[0].c1;
    #12;
    check("rst_ready", {30'd0, bus.req_ready}, 32'd0);
    check("rst_cfg", cfg_now(), 32'd0);
    check("rst_start", {31'd0, gen_start}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_grant_id", {31'd0, grant_id}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
`ifdef VRF_SCHED_TIMEOUT_EN
    check("rst_error", {31'd0, error_o}, 32'd0);
`endif
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) run_txn(tbl[i], $sformatf("v%0d", i));
    prev_int_exp = 0;

    // Generator not ready in IDLE: no grant for 10 cycles, grant as soon as it rises.
    cx = vrf_cmd_t'(CMD_W'($urandom));
    cx.vl = VLW'(7);
    @(posedge clk); #1;
    gen_ready     = 1'b0;
    bus.req_valid = 2'b01;
    bus.req0_cmd  = cx;
    repeat (10) begin
      @(negedge clk);
      check("stall_ready", {30'd0, bus.req_ready}, 32'd0);
      check("stall_busy", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
    end
    gen_ready = 1'b1;
    @(negedge clk);
    check("stall_grant", {30'd0, bus.req_ready}, 32'd1);
    e.id = 1'b0; e.cmd = cx; sb.push_back(e);
    complete_txn(cx, 1, "stall");

    // Reset while waiting in RUN; pointer was left at requester 1.
    cx = vrf_cmd_t'(CMD_W'($urandom));
    cx.vl = VLW'(10);
    @(posedge clk); #1;
    bus.req_valid = 2'b01;
    bus.req0_cmd  = cx;
    bus.req1_cmd  = tbl[3].c1;
    @(negedge clk);
    check("rr_pre_grant", {30'd0, bus.req_ready}, 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    @(posedge clk); #1;
    gen_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rr_pre_busy", {31'd0, busy}, 32'd1);
    #2;
    bus.req_valid = 2'b11;
    gen_ready     = 1'b1;
    rst_n         = 1'b0;
    #1;
    check("midrst_ready", {30'd0, bus.req_ready}, 32'd0);
    check("midrst_cfg", cfg_now(), 32'd0);
    check("midrst_start", {31'd0, gen_start}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_grant_id", {31'd0, grant_id}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_rr", {30'd0, bus.req_ready}, 32'd1);
    e.id = 1'b0; e.cmd = cx; sb.push_back(e);
    complete_txn(cx, 0, "postrst");

`ifdef VRF_SCHED_TIMEOUT_EN
    // Generator never returns to ready: watchdog fires after 16 RUN cycles.
    cx = vrf_cmd_t'(CMD_W'($urandom));
    cx.vl = VLW'(20);
    @(posedge clk); #1;
    bus.req_valid = 2'b01;
    bus.req0_cmd  = cx;
    gen_ready     = 1'b1;
    @(negedge clk);
    check("to_grant", {30'd0, bus.req_ready}, 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    gen_ready     = 1'b0;
    k = 1;
    @(negedge clk);
    while (error_o !== 1'b1 && k < 60) begin
      @(negedge clk);
      k++;
    end
    check("to_cycle", k, 32'd19);
    check("to_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    check("to_sticky", {31'd0, error_o}, 32'd1);
    check("to_idle", {31'd0, busy}, 32'd0);
    sb.delete();
`endif

    repeat (3) @(negedge clk);
    check("done_count", done_cnt, done_exp);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vrf_access_scheduler.md
# vrf_access_scheduler

Sequencing and arbitration controller in front of `VRF_BRAM_addr_generator`. Two requesters compete for the single vector-register-file address generator: requester 0 is the arithmetic issue stage and requester 1 is the load/store unit. The scheduler grants one request at a time using round-robin priority, then drives the generator's configuration inputs stable for the whole operation. It fires a one-cycle start and reports completion when the generator returns to ready.

## Interface
- `VECTOR_LENGTH`, 1024, elements per vector register; sets the `vector_length` width `VLW = $clog2(VECTOR_LENGTH/32)+1`.
- `TIMEOUT_CYCLES`, 4096, watchdog limit; used only with `VRF_SCHED_TIMEOUT_EN`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `req_valid_i` in 2: per-requester command valid.
- `req_ready_o` out 2: one-hot grant; a request is accepted when `valid & ready` are both high.
- `req0_cmd_i`, `req1_cmd_i` in `CMD_W`: packed `{type[1:0], vs1[4:0], vs2[4:0], vd[4:0], vmul[1:0], vl[VLW-1:0], alu_exe_time[2:0]}`.
- `vrf_type_of_access_o` out 2, `vs1_address_o` out 5, `vs2_address_o` out 5, `vd_address_o` out 5, `vmul_o` out 2, `vector_length_o` out `VLW`, `alu_exe_time_o` out 3: generator configuration, registered.
- `gen_start_o` out 1: one-cycle start pulse to the generator.
- `gen_ready_i` in 1: the generator's `ready_o`.
- `busy_o` out 1: high in every state except IDLE.
- `grant_id_o` out 1: requester owning the current or last operation.
- `done_o` out 1: one-cycle completion pulse.
- `error_o` out 1: sticky timeout flag; present only with the macro.

## Operation
- States: IDLE, START, ACK, RUN.
- **IDLE.** The scheduler grants only when `gen_ready_i=1` and at least one valid is high. It picks the requester given by the round-robin pointer `rr`; if that requester is not valid, the other one wins. `req_ready_o` is combinational and asserted in IDLE only.
  - On accept: latch the command into the output registers, set `grant_id_o`, set `rr` to the opposite requester, and go to START.
  - If the latched `vl=0`, skip START and go directly to a done cycle: `done_o=1` next cycle, return to IDLE, and never assert `gen_start_o`.
- **START.** `gen_start_o=1` for exactly one cycle, then go to ACK.
- **ACK.** Blanking cycle; `gen_ready_i` is ignored, because the generator drops ready one cycle after start. Go to RUN.
- **RUN.** Wait for `gen_ready_i=1`. When it arrives, pulse `done_o` for one cycle and return to IDLE in the same transition.
- Configuration outputs hold their value from accept until the next accept. They never change while `busy_o=1`.
- If both requesters are valid on every opportunity, grants alternate 0, 1, 0, 1, … .
- If `gen_ready_i=0` in IDLE, no grant is issued and requests stall with no loss.
- **Reset (any state, including mid-operation).** State goes to IDLE and `rr`=0. All outputs reset to 0: `req_ready_o`, configuration outputs, `gen_start_o`, `busy_o`, `grant_id_o`, `done_o`, `error_o`.
  - An operation interrupted by reset is abandoned; no `done_o` is issued for it.

## Timing
- Accept happens in cycle N (IDLE).
- `gen_start_o` is high in cycle N+1.
- ACK occupies cycle N+2.
- The earliest `done_o` is in cycle N+3, if `gen_ready_i` is already high in RUN.
- For the `vl=0` case, `done_o` is in cycle N+1.
- The next accept can occur in the cycle after `done_o`. Minimum issue interval is 4 cycles, or 2 cycles for `vl=0`.
- `done_o` and `req_ready_o` are never high in the same cycle.

## Configuration
- `VRF_SCHED_TIMEOUT_EN` defined:
  - A counter is cleared on entry to RUN and increments each RUN cycle.
  - When it reaches `TIMEOUT_CYCLES`, the scheduler sets the sticky `error_o`, forces IDLE, and suppresses `done_o`.
  - `error_o` is cleared only by reset.
- `VRF_SCHED_TIMEOUT_EN` undefined: there is no counter and no `error_o` port, and RUN waits indefinitely.

## Structure
- Package `vrf_sched_pkg` holds:
  - the state enum `vrf_sched_state_t`;
  - the command struct `vrf_cmd_t`, with `CMD_W` derived from it;
  - the field widths, with `VLW` as a function of `VECTOR_LENGTH`.
- Sub-module `vrf_rr_arbiter` is a 2-way round-robin grant with pointer update on accept. The top level holds the FSM, the output registers and the watchdog.

## Test plan
- After reset, with both valid, `gen_ready_i=1`, and `req0` vl=32 type=2'b11: `req_ready_o=2'b01` in N, `gen_start_o` in N+1, and outputs match `req0`. `gen_ready_i` is held 0 for 5 cycles after ACK then raised, giving `done_o` in N+8.
- Both valid continuously, generator completing instantly: grant sequence is 0, 1, 0, 1 with accepts every 4 cycles, and the outputs never change while `busy_o=1`.
- `req1` only, with vl=0: `done_o` in N+1, `gen_start_o` stays 0, and `rr` points to 0 afterwards.
- `gen_ready_i=0` in IDLE with `req0` valid: `req_ready_o=0` for 10 cycles. When ready rises, the grant comes in the same cycle.
- Reset asserted during RUN: all outputs are 0 asynchronously, there is no `done_o`, and the next grant goes to requester 0.
- With `VRF_SCHED_TIMEOUT_EN` and `TIMEOUT_CYCLES=16`, `gen_ready_i` stuck at 0 in RUN: `error_o` rises after 16 RUN cycles, the FSM returns to IDLE, and there is no `done_o`.
